// File: rtl/glip_uart_tx_scheduler_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : glip_uart_tx_scheduler_if                                    |
// | Purpose   : Byte-stream handshakes around the egress transmit scheduler: |
// |             FWFT buffer head (valid/data/pop) on the ingress side and    |
// |             the UART transmitter enable/done handshake on the egress     |
// |             side.                                                        |
// | Modports  : master - the scheduler (pops the buffer, drives the tx)      |
// |             slave  - the environment (buffer + transmitter)              |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
interface glip_uart_tx_scheduler_if;

  // FWFT egress buffer head
  logic [7:0] data_in_data;
  logic       data_in_valid;
  logic       data_in_ready;

  // UART transmitter handshake
  logic [7:0] tx_data;
  logic       tx_enable;
  logic       tx_done;

  modport master (
    input  data_in_data,
    input  data_in_valid,
    output data_in_ready,
    output tx_data,
    output tx_enable,
    input  tx_done
  );

  modport slave (
    output data_in_data,
    output data_in_valid,
    input  data_in_ready,
    input  tx_data,
    input  tx_enable,
    output tx_done
  );

endinterface : glip_uart_tx_scheduler_if
`default_nettype wire

// File: rtl/glip_uart_tx_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : glip_uart_tx_scheduler                                       |
// | Purpose   : Egress transmit scheduler (I/O clock domain). Arbitrates     |
// |             between credit-gated payload bytes (escape-stuffed) and      |
// |             credit-grant control frames, presenting one byte at a time   |
// |             on the transmitter enable/done handshake.                    |
// | Options   : GLIP_UART_TX_SCHED_STATS_EN adds stat_data_bytes and         |
// |             stat_ctrl_frames counters.                                   |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module glip_uart_tx_scheduler #(
  parameter int         CREDIT_WIDTH   = 15,
  parameter logic [7:0] ESCAPE         = 8'hFE,
  parameter int         MAX_DATA_BURST = 64
) (
  input  wire logic                    clk,
  input  wire logic                    rst_n,

  glip_uart_tx_scheduler_if.master     bus_if,

  input  wire logic                    credit_req,
  input  wire logic [CREDIT_WIDTH-1:0] credit_value,
  output logic                         credit_ack,

  input  wire logic                    host_credit_add_valid,
  input  wire logic [CREDIT_WIDTH-1:0] host_credit_add,

  output logic [CREDIT_WIDTH-1:0]      host_credit,
  output logic                         overflow
`ifdef GLIP_UART_TX_SCHED_STATS_EN
  ,
  output logic [31:0]                  stat_data_bytes,
  output logic [31:0]                  stat_ctrl_frames
`endif
);

  localparam int BURST_W = $clog2(MAX_DATA_BURST + 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_DATA_BURST);
  localparam logic [CREDIT_WIDTH+1:0] CREDIT_SAT = {2'b00, {CREDIT_WIDTH{1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DATA     = 3'd1,
    S_DATA_ESC = 3'd2,
    S_CRED_HDR = 3'd3,
    S_CRED_HI  = 3'd4,
    S_CRED_LO  = 3'd5
  } state_t;

  state_t                   state_q;
  logic [7:0]               tx_data_q;
  logic                     tx_enable_q;
  logic                     data_in_ready_q;
  logic                     credit_ack_q;

  logic [CREDIT_WIDTH-1:0]  host_credit_q, host_credit_d;
  logic                     overflow_q, overflow_d;
  logic                     pending_q, pending_d;
  logic [CREDIT_WIDTH-1:0]  value_q, value_d;
  logic [BURST_W-1:0]       burst_cnt_q, burst_cnt_d;
  logic [CREDIT_WIDTH-1:0]  frame_q;

  logic                     eligible;
  logic                     go_cred;
  logic                     go_data;
  logic                     byte_done;
  logic [CREDIT_WIDTH+1:0]  credit_sum;
  logic [14:0]              frame_ext;

  // Arbitration terms and the transmitter-completion qualifier
  always_comb begin
    eligible  = bus_if.data_in_valid && (host_credit_q != '0);
    go_cred   = (state_q == S_IDLE) && pending_q &&
                ((burst_cnt_q == BURST_MAX) || !eligible);
    go_data   = (state_q == S_IDLE) && !go_cred && eligible;
    // tx_done only counts while a byte is actually being offered
    byte_done = tx_enable_q && bus_if.tx_done;
    frame_ext = 15'(frame_q);
  end

  // Next host credit: net add/decrement, saturating with a sticky overflow flag
  always_comb begin
    credit_sum    = {2'b00, host_credit_q}
                  + (host_credit_add_valid ? {2'b00, host_credit_add} : '0)
                  - {{(CREDIT_WIDTH+1){1'b0}}, go_data};
    host_credit_d = credit_sum[CREDIT_WIDTH-1:0];
    overflow_d    = overflow_q;
    if (credit_sum > CREDIT_SAT) begin
      host_credit_d = {CREDIT_WIDTH{1'b1}};
      overflow_d    = 1'b1;
    end
  end

  // Pending grant request (latest value wins) and payload burst counter
  always_comb begin
    pending_d   = pending_q;
    value_d     = value_q;
    burst_cnt_d = burst_cnt_q;
    if (go_cred) begin
      pending_d = 1'b0;
    end
    // A request in the same cycle as frame launch re-arms for the next frame
    if (credit_req) begin
      pending_d = 1'b1;
      value_d   = credit_value;
    end
    if (go_cred || ((state_q == S_IDLE) && !eligible)) begin
      burst_cnt_d = '0;
    end else if (go_data && (burst_cnt_q != BURST_MAX)) begin
      burst_cnt_d = burst_cnt_q + 1'b1;
    end
  end

  // Bookkeeping registers: credit, overflow, pending grant, burst count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_credit_q <= '0;
      overflow_q    <= 1'b0;
      pending_q     <= 1'b0;
      value_q       <= '0;
      burst_cnt_q   <= '0;
    end else begin
      host_credit_q <= host_credit_d;
      overflow_q    <= overflow_d;
      pending_q     <= pending_d;
      value_q       <= value_d;
      burst_cnt_q   <= burst_cnt_d;
    end
  end

  // Scheduler FSM with registered handshake outputs; every emitting state
  // raises tx_enable with its byte, then drops it on the qualified tx_done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      tx_data_q       <= '0;
      tx_enable_q     <= 1'b0;
      data_in_ready_q <= 1'b0;
      credit_ack_q    <= 1'b0;
      frame_q         <= '0;
    end else begin
      data_in_ready_q <= 1'b0;
      credit_ack_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (go_cred) begin
            state_q     <= S_CRED_HDR;
            frame_q     <= value_q;
            tx_data_q   <= ESCAPE;
            tx_enable_q <= 1'b1;
          end else if (go_data) begin
            state_q         <= S_DATA;
            tx_data_q       <= bus_if.data_in_data;
            tx_enable_q     <= 1'b1;
            data_in_ready_q <= 1'b1;
          end
        end
        S_DATA: begin
          if (byte_done) begin
            tx_enable_q <= 1'b0;
            state_q     <= (tx_data_q == ESCAPE) ? S_DATA_ESC : S_IDLE;
          end
        end
        S_DATA_ESC: begin
          if (!tx_enable_q) begin
            tx_data_q   <= ESCAPE;
            tx_enable_q <= 1'b1;
          end else if (bus_if.tx_done) begin
            tx_enable_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        S_CRED_HDR: begin
          if (byte_done) begin
            tx_enable_q <= 1'b0;
            state_q     <= S_CRED_HI;
          end
        end
        S_CRED_HI: begin
          if (!tx_enable_q) begin
            tx_data_q   <= {1'b1, frame_ext[14:8]};
            tx_enable_q <= 1'b1;
          end else if (bus_if.tx_done) begin
            tx_enable_q <= 1'b0;
            state_q     <= S_CRED_LO;
          end
        end
        S_CRED_LO: begin
          if (!tx_enable_q) begin
            tx_data_q   <= frame_ext[7:0];
            tx_enable_q <= 1'b1;
          end else if (bus_if.tx_done) begin
            tx_enable_q  <= 1'b0;
            credit_ack_q <= 1'b1;
            state_q      <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          tx_enable_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus_if.tx_data       = tx_data_q;
  assign bus_if.tx_enable     = tx_enable_q;
  assign bus_if.data_in_ready = data_in_ready_q;
  assign credit_ack           = credit_ack_q;
  assign host_credit          = host_credit_q;
  assign overflow             = overflow_q;

`ifdef GLIP_UART_TX_SCHED_STATS_EN
  logic [31:0] stat_data_q;
  logic [31:0] stat_ctrl_q;
  logic        data_byte_done;

  // A stuffed escape counts as one payload byte, completed by its second copy
  always_comb begin
    data_byte_done = byte_done &&
                     (((state_q == S_DATA) && (tx_data_q != ESCAPE)) ||
                      (state_q == S_DATA_ESC));
  end

  // Free-running (wrapping) statistics counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_data_q <= '0;
      stat_ctrl_q <= '0;
    end else begin
      if (data_byte_done) begin
        stat_data_q <= stat_data_q + 32'd1;
      end
      if (byte_done && (state_q == S_CRED_LO)) begin
        stat_ctrl_q <= stat_ctrl_q + 32'd1;
      end
    end
  end

  assign stat_data_bytes  = stat_data_q;
  assign stat_ctrl_frames = stat_ctrl_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule : glip_uart_tx_scheduler
`default_nettype wire

// File: tb/tb_glip_uart_tx_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : tb_glip_uart_tx_scheduler                                    |
// | Purpose   : Directed self-checking bench for glip_uart_tx_scheduler with |
// |             an FWFT buffer model and a fixed-latency transmitter model.  |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module tb_glip_uart_tx_scheduler;

  localparam int CW     = 15;
  localparam int TX_DLY = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          credit_req;
  logic [CW-1:0] credit_value;
  logic          credit_ack;
  logic          host_credit_add_valid;
  logic [CW-1:0] host_credit_add;
  logic [CW-1:0] host_credit;
  logic          overflow;
`ifdef GLIP_UART_TX_SCHED_STATS_EN
  logic [31:0]   stat_data_bytes;
  logic [31:0]   stat_ctrl_frames;
`endif

  glip_uart_tx_scheduler_if bus ();

  glip_uart_tx_scheduler #(
    .CREDIT_WIDTH   (CW),
    .ESCAPE         (8'hFE),
    .MAX_DATA_BURST (64)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .bus_if                (bus),
    .credit_req            (credit_req),
    .credit_value          (credit_value),
    .credit_ack            (credit_ack),
    .host_credit_add_valid (host_credit_add_valid),
    .host_credit_add       (host_credit_add),
    .host_credit           (host_credit),
    .overflow              (overflow)
`ifdef GLIP_UART_TX_SCHED_STATS_EN
    ,
    .stat_data_bytes       (stat_data_bytes),
    .stat_ctrl_frames      (stat_ctrl_frames)
`endif
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] wire_q[$];
  logic [7:0] buf_mem [0:511];
  int         buf_wr = 0;
  int         buf_rd = 0;
  int         ready_cnt = 0;
  int         ack_cnt = 0;
  int         ack_wire_sz = -1;
  int         stable_err = 0;
  int         base;
  int         r0;
  int         a0;
  logic [7:0] exp2 [4] = '{8'h10, 8'hFE, 8'hFE, 8'h20};
  logic [7:0] exp3 [3] = '{8'hFE, 8'h92, 8'h34};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] wire_at(input int i);
    if (i < wire_q.size()) return wire_q[i];
    return 8'hxx;
  endfunction

  // Main-process stimulus lands 1ns after the falling edge
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    repeat (n) tick();
  endtask

  task automatic push(input logic [7:0] b);
    buf_mem[buf_wr] = b;
    buf_wr++;
  endtask

  task automatic add_credit(input int a);
    host_credit_add       = CW'(a);
    host_credit_add_valid = 1'b1;
    tick();
    host_credit_add_valid = 1'b0;
    host_credit_add       = '0;
  endtask

  task automatic req_credit(input int v);
    credit_value = CW'(v);
    credit_req   = 1'b1;
    tick();
    credit_req   = 1'b0;
  endtask

  task automatic wait_wire(input int n);
    int c;
    c = 0;
    while (wire_q.size() < n && c < 3000) begin
      tick();
      c++;
    end
    if (wire_q.size() < n) chk("wire_timeout", wire_q.size(), n);
  endtask

  // FWFT buffer model: pops on data_in_ready, presents the new head
  initial begin
    bus.data_in_valid = 1'b0;
    bus.data_in_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.data_in_ready === 1'b1) begin
        ready_cnt++;
        if (buf_rd != buf_wr) buf_rd++;
      end
      if (credit_ack === 1'b1) begin
        ack_cnt++;
        ack_wire_sz = wire_q.size();
      end
      bus.data_in_valid = (buf_rd != buf_wr);
      bus.data_in_data  = (buf_rd != buf_wr) ? buf_mem[buf_rd] : 8'h00;
    end
  end

  // Transmitter model: captures each offered byte, holds for TX_DLY cycles,
  // pulses tx_done once; aborts when reset is asserted mid-byte
  initial begin
    logic [7:0] cap;
    bus.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.tx_enable === 1'b1) begin
        cap = bus.tx_data;
        wire_q.push_back(cap);
        for (int k = 0; k < TX_DLY; k++) begin
          @(negedge clk);
          if (rst_n !== 1'b1) break;
          if (bus.tx_enable !== 1'b1 || bus.tx_data !== cap) stable_err++;
        end
        if (rst_n === 1'b1) begin
          bus.tx_done = 1'b1;
          @(negedge clk);
          bus.tx_done = 1'b0;
        end
      end
    end
  end

  initial begin
    rst_n                 = 1'b0;
    credit_req            = 1'b0;
    credit_value          = '0;
    host_credit_add_valid = 1'b0;
    host_credit_add       = '0;
    settle(3);

    // Reset state
    chk("rst_tx_enable", bus.tx_enable, 0);
    chk("rst_tx_data", bus.tx_data, 0);
    chk("rst_data_in_ready", bus.data_in_ready, 0);
    chk("rst_credit_ack", credit_ack, 0);
    chk("rst_host_credit", host_credit, 0);
    chk("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    settle(2);

    // No credit: byte stays queued; one credit releases it exactly once
    base = wire_q.size(); r0 = ready_cnt;
    push(8'h41);
    settle(12);
    chk("t1_gated_bytes", wire_q.size() - base, 0);
    chk("t1_gated_ready", ready_cnt - r0, 0);
    add_credit(1);
    wait_wire(base + 1);
    settle(10);
    chk("t1_byte", wire_at(base), 8'h41);
    chk("t1_count", wire_q.size() - base, 1);
    chk("t1_ready", ready_cnt - r0, 1);
    chk("t1_credit", host_credit, 0);

    // Escape stuffing: FE is doubled but consumes a single credit
    base = wire_q.size(); r0 = ready_cnt;
    push(8'h10); push(8'hFE); push(8'h20);
    add_credit(5);
    wait_wire(base + 4);
    settle(10);
    for (int i = 0; i < 4; i++) chk("t2_byte", wire_at(base + i), exp2[i]);
    chk("t2_count", wire_q.size() - base, 4);
    chk("t2_ready", ready_cnt - r0, 3);
    chk("t2_credit", host_credit, 2);

    // Credit grant frame with no payload waiting
    base = wire_q.size(); a0 = ack_cnt;
    req_credit(32'h1234);
    wait_wire(base + 3);
    settle(10);
    for (int i = 0; i < 3; i++) chk("t3_byte", wire_at(base + i), exp3[i]);
    chk("t3_count", wire_q.size() - base, 3);
    chk("t3_ack_pulses", ack_cnt - a0, 1);
    chk("t3_ack_after_last", ack_wire_sz, base + 3);

    // Burst limit: pending grant waits for 64 payload bytes
    add_credit(198);
    settle(2);
    chk("t4_credit_start", host_credit, 200);
    base = wire_q.size();
    for (int i = 1; i <= 100; i++) push(8'(i));
    wait_wire(base + 3);
    req_credit(32'h0055);
    wait_wire(base + 103);
    settle(10);
    chk("t4_first", wire_at(base + 0), 8'd1);
    chk("t4_byte64", wire_at(base + 63), 8'd64);
    chk("t4_hdr", wire_at(base + 64), 8'hFE);
    chk("t4_hi", wire_at(base + 65), 8'h80);
    chk("t4_lo", wire_at(base + 66), 8'h55);
    chk("t4_byte65", wire_at(base + 67), 8'd65);
    chk("t4_last", wire_at(base + 102), 8'd100);
    chk("t4_count", wire_q.size() - base, 103);
    chk("t4_credit_end", host_credit, 100);

    // Saturation and sticky overflow
    add_credit(32'h7F9A);
    settle(2);
    chk("t5_credit_7ffe", host_credit, 32'h7FFE);
    chk("t5_no_overflow", overflow, 0);
    add_credit(3);
    chk("t5_credit_sat", host_credit, 32'h7FFF);
    chk("t5_overflow", overflow, 1);
    settle(5);
    chk("t5_overflow_sticky", overflow, 1);

    // Asynchronous reset while the grant high byte is on the wire
    base = wire_q.size(); a0 = ack_cnt;
    req_credit(32'h0ABC);
    wait_wire(base + 2);
    chk("t6_hi_byte", wire_at(base + 1), 8'h8A);
    rst_n = 1'b0;
    #1;
    chk("t6_async_enable", bus.tx_enable, 0);
    settle(3);
    rst_n = 1'b1;
    settle(20);
    chk("t6_no_more_bytes", wire_q.size() - base, 2);
    chk("t6_no_ack", ack_cnt - a0, 0);
    chk("t6_credit", host_credit, 0);
    chk("t6_overflow_clr", overflow, 0);

    // Add and DATA-entry decrement in the same cycle net to zero change
    add_credit(4);
    settle(2);
    base = wire_q.size();
    push(8'h33);
    tick();
    add_credit(1);
    chk("t7_net_credit", host_credit, 4);
    wait_wire(base + 1);
    settle(10);
    chk("t7_byte", wire_at(base), 8'h33);
    chk("t7_credit_end", host_credit, 4);

    chk("tx_data_stable", stable_err, 0);
`ifdef GLIP_UART_TX_SCHED_STATS_EN
    chk("stat_data_bytes", stat_data_bytes, 1);
    chk("stat_ctrl_frames", stat_ctrl_frames, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_glip_uart_tx_scheduler
`default_nettype wire

// File: doc/glip_uart_tx_scheduler.md
Name: glip_uart_tx_scheduler

Overview:
Egress transmit scheduler in the I/O clock domain. It sits between the egress byte buffer and the UART transmitter, and arbitrates between payload bytes and credit-grant control frames. Payload bytes are gated by a host-credit counter, and payload bytes equal to the escape code are escape-stuffed. Exactly one byte at a time is presented on the transmitter's enable/done handshake.

Parameters:
CREDIT_WIDTH, 15, width of host-credit counter and of credit grant value
ESCAPE, 8'hFE, escape/control-frame marker byte
MAX_DATA_BURST, 64, consecutive payload bytes allowed while a credit grant is pending

Ports:
clk  input  1  I/O clock
rst_n  input  1  asynchronous active-low reset
data_in_data  input  8  payload byte from FWFT buffer head
data_in_valid  input  1  buffer not empty
data_in_ready  output  1  one-cycle pop strobe to buffer
credit_req  input  1  pulse: request a credit grant frame be sent to host
credit_value  input  CREDIT_WIDTH  grant value, sampled with credit_req
credit_ack  output  1  pulse: grant frame fully transmitted
host_credit_add_valid  input  1  pulse: host granted credit
host_credit_add  input  CREDIT_WIDTH  amount granted
tx_data  output  8  byte to transmitter
tx_enable  output  1  byte valid, held until tx_done
tx_done  input  1  one-cycle pulse: transmitter finished byte
host_credit  output  CREDIT_WIDTH  current payload credit
overflow  output  1  sticky: host credit add saturated

Behaviour:
- Reset (async, rst_n=0): state IDLE; tx_enable=0, tx_data=0, data_in_ready=0, credit_ack=0, host_credit=0, overflow=0, pending=0, burst_cnt=0. Reset mid-byte aborts immediately; the transmitter owner resets it on the same reset.
- States: IDLE, DATA, DATA_ESC, CRED_HDR, CRED_HI, CRED_LO.
- Payload eligible = data_in_valid & host_credit!=0.
- Arbitration in IDLE:
  - pending & (burst_cnt==MAX_DATA_BURST | !eligible) -> CRED_HDR.
  - else eligible -> DATA.
  - else stay in IDLE.
- Entering DATA:
  - Latch data_in_data into the byte register.
  - Assert data_in_ready for exactly that cycle.
  - Decrement host_credit by 1; burst_cnt++ (saturating at MAX_DATA_BURST).
- Entering CRED_HDR: freeze the latched grant value; clear pending; burst_cnt=0.
- tx_enable rises the cycle after the IDLE decision (1-cycle latency). tx_data stays stable while tx_enable=1. tx_enable deasserts in the cycle tx_done is seen, then the next state is entered.
- DATA emits the byte. On tx_done:
  - If byte==ESCAPE, go to DATA_ESC, which emits ESCAPE again. This costs 1 credit total.
  - Else go to IDLE.
- Control frame:
  - CRED_HDR emits ESCAPE.
  - CRED_HI emits {1'b1, value[14:8]}.
  - CRED_LO emits value[7:0].
  - credit_ack pulses in the cycle tx_done for CRED_LO is seen; then go to IDLE.
- credit_req while pending=1 overwrites the value (latest wins). credit_req during CRED_* sets pending again for a new frame; the in-flight value is unaffected.
- host_credit update: next = host_credit + (add_valid ? add : 0) - (DATA entry ? 1 : 0).
  - Saturate at 2^CREDIT_WIDTH-1 and set overflow if the true sum exceeds it.
  - Simultaneous add and decrement use net arithmetic.
- burst_cnt resets to 0 whenever IDLE finds no eligible payload.
- tx_done outside tx_enable is ignored.

Optional Feature:
GLIP_UART_TX_SCHED_STATS_EN
- Defined: adds outputs stat_data_bytes [31:0] and stat_ctrl_frames [31:0], both reset to 0.
  - stat_data_bytes counts completed payload bytes; an escaped byte counts as 1.
  - stat_ctrl_frames counts credit_ack pulses.
  - Both counters wrap at 2^32.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Credit=0, buffer holds 0x41 -> no tx_enable. add 1 -> 0x41 sent once, data_in_ready pulses once, host_credit ends 0.
- host_credit=5, bytes 0x10,0xFE,0x20 -> wire 0x10,0xFE,0xFE,0x20; host_credit ends 2.
- credit_req value 0x1234 with idle data -> wire 0xFE,0x92,0x34; credit_ack pulses on the last tx_done.
- host_credit=200, 100 bytes queued, credit_req after byte 3 -> grant frame starts after byte 64; payload resumes at byte 65.
- host_credit=0x7FFE, add 3 -> host_credit=0x7FFF, overflow=1 and stays set. Simultaneous add 1 and DATA entry at credit 4 -> credit 4.
- rst_n low while CRED_HI is in flight -> tx_enable=0 asynchronously. After release, state is IDLE, pending=0, and no credit_ack occurs.
